mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum ACCESS cycles without Device_Ready before abort; legal range 1..255.
REQ-002 Parameter RD_ERR_VALUE, default 32'h0000_0000: rdata value returned on a timed-out read.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_req  in  1  requester 0 (CPU) access request, level.
REQ-006 m0_we  in  1  requester 0: 1 = write, 0 = read.
REQ-007 m0_addr  in  32  requester 0 byte address.
REQ-008 m0_wdata  in  32  requester 0 write data.
REQ-009 m1_req  in  1  requester 1 (loader/DMA) access request, level.
REQ-010 m1_we  in  1  requester 1: 1 = write, 0 = read.
REQ-011 m1_addr  in  32  requester 1 byte address.
REQ-012 m1_wdata  in  32  requester 1 write data.
REQ-013 gnt  out  2  one-hot grant; bit i = requester i owns bus.
REQ-014 done  out  2  one-cycle completion pulse; bit i = requester i.
REQ-015 rdata  out  32  read data, shared; valid while done is high.
REQ-016 err  out  1  timeout flag; high with done on an aborted access.
REQ-017 MemBus_Address  out  32  shared bus address, registered.
REQ-018 MemBus_Write_Data  out  32  shared bus write data, registered.
REQ-019 MemRead  out  1  bus read strobe, registered.
REQ-020 MemWrite  out  1  bus write strobe, registered.
REQ-021 Device_Read_Data  in  32  read data returned by the addressed device.
REQ-022 Device_Ready  in  1  device completes the current access this cycle.

Function
REQ-023 The FSM SHALL have states IDLE, ACCESS, and DONE.
REQ-024 IDLE: no request -> stay; any req -> ACCESS at the next edge.
REQ-025 Arbitration: a single requester wins; if both request, the winner is the requester not granted last (round-robin pointer last_gnt).
REQ-026 At the IDLE->ACCESS edge: gnt, MemBus_Address, MemBus_Write_Data, and the we-derived strobe (MemWrite = we, MemRead = ~we) load from the winner; only the winner's inputs are sampled.
REQ-027 Requester inputs changing, or req dropping, after the grant edge SHALL be ignored; the transaction completes.
REQ-028 ACCESS: timeout counter starts at 0 and increments each cycle Device_Ready is low.
REQ-029 ACCESS with Device_Ready=1 at an edge -> DONE: strobes deassert, done[winner]=1, rdata = Device_Read_Data for reads, rdata unchanged for writes, err=0.
REQ-030 ACCESS reaching counter == TIMEOUT with Device_Ready=0 -> DONE with err=1, rdata = RD_ERR_VALUE for reads, strobes deasserted.
REQ-031 Device_Ready=1 in the same cycle the counter reaches TIMEOUT SHALL count as success (err=0).
REQ-032 DONE SHALL last exactly one cycle, then IDLE; requests are not sampled in DONE; done and err clear on leaving DONE.
REQ-033 gnt SHALL stay held through ACCESS and DONE and clear in IDLE; last_gnt updates at the grant edge.
REQ-034 Latency: with Device_Ready tied high, req sampled at edge k gives strobes high in cycle k..k+1 (one cycle) and done high in the following cycle; requester-visible latency is 2 cycles.
REQ-035 MemBus_Address and MemBus_Write_Data SHALL hold their last value in IDLE; MemRead and MemWrite are never both high.

Reset
REQ-036 On reset, the following SHALL take their reset values at the next edge: state=IDLE, gnt=0, done=0, err=0, rdata=0, MemBus_Address=0, MemBus_Write_Data=0, MemRead=0, MemWrite=0, counter=0, last_gnt=1 (requester 0 wins the first tie).
REQ-037 Reset asserted mid-ACCESS or in DONE SHALL abort with no done pulse; reset takes priority over every other input.

Verification
REQ-038 The bench SHALL cover m0 read of addr 0x4000_0010 with Device_Ready=1 and Device_Read_Data=0x1234_5678 -> gnt=01, MemRead for 1 cycle, done=01 next cycle, rdata=0x1234_5678, err=0.
REQ-039 The bench SHALL cover m0 and m1 requesting simultaneously from reset, both held -> grant order m0, m1, m0, m1 with one idle cycle between each DONE and the next grant.
REQ-040 The bench SHALL cover m1 write of 0xCAFE_F00D with Device_Ready low for 3 cycles -> MemWrite high 4 cycles, then done=10, err=0, rdata unchanged.
REQ-041 The bench SHALL cover m0 read with Device_Ready never high and TIMEOUT=15 -> MemRead high 16 cycles, then done=01, err=1, rdata=0.
REQ-042 The bench SHALL cover Device_Ready rising on the cycle the counter equals TIMEOUT -> err=0 and rdata taken from Device_Read_Data.
REQ-043 The bench SHALL cover reset asserted during ACCESS with m1 granted -> next cycle all outputs 0, no done pulse, and on release a simultaneous m0/m1 request is granted to m0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester ports, the shared memory bus and the device return path.
// Latency: none, wiring only.
// Backpressure: carried by the req/gnt/done handshake and Device_Ready inside the bundle.
interface mem_bus_arbiter_if;
  // requester 0 (CPU)
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  // requester 1 (loader/DMA)
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  // requester-facing results
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        err;
  // shared memory bus
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Device_Read_Data;
  logic        Device_Ready;

  // arbiter side: it masters the memory bus and serves both requesters
  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  Device_Read_Data, Device_Ready,
    output gnt, done, rdata, err,
    output MemBus_Address, MemBus_Write_Data, MemRead, MemWrite
  );

  // environment side: requesters plus the addressed device
  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output Device_Read_Data, Device_Ready,
    input  gnt, done, rdata, err,
    input  MemBus_Address, MemBus_Write_Data, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter, round-robin on ties, one transaction in flight, device timeout abort.
// Latency: grant and strobes one edge after req; done/rdata one edge after Device_Ready (or timeout).
// Backpressure: requesters hold req until granted; the device stalls ACCESS by holding Device_Ready low.
module mem_bus_arbiter #(
  parameter int          TIMEOUT      = 15,
  parameter logic [31:0] RD_ERR_VALUE = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.master io_bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACCESS   = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]  r_state;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [7:0]  r_cnt;
  logic        r_last_gnt;   // index of the requester granted most recently

  logic        w_any_req;
  logic        w_win;        // index of the requester that would win right now
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  // Arbitrate: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    w_any_req = io_bus.m0_req | io_bus.m1_req;
    if (io_bus.m0_req && io_bus.m1_req) begin
      w_win = ~r_last_gnt;
    end else begin
      w_win = io_bus.m1_req;
    end
    w_we    = w_win ? io_bus.m1_we    : io_bus.m0_we;
    w_addr  = w_win ? io_bus.m1_addr  : io_bus.m0_addr;
    w_wdata = w_win ? io_bus.m1_wdata : io_bus.m0_wdata;
  end

  // Transaction sequencer: latch the winner, wait for the device or the timeout, pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_cnt       <= 8'd0;
      r_last_gnt  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state     <= S_ACCESS;
            r_gnt       <= w_win ? 2'b10 : 2'b01;
            r_last_gnt  <= w_win;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_mem_write <= w_we;
            r_mem_read  <= ~w_we;
            r_cnt       <= 8'd0;
          end
        end
        S_ACCESS: begin
          // Device_Ready wins over the timeout when both land on the same edge.
          if (io_bus.Device_Ready) begin
            r_state     <= S_DONE;
            r_done      <= r_gnt;
            r_err       <= 1'b0;
            if (r_mem_read) begin
              r_rdata <= io_bus.Device_Read_Data;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end else if (r_cnt == LP_TIMEOUT) begin
            r_state     <= S_DONE;
            r_done      <= r_gnt;
            r_err       <= 1'b1;
            if (r_mem_read) begin
              r_rdata <= RD_ERR_VALUE;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_gnt   <= 2'b00;
          r_done  <= 2'b00;
          r_err   <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= 2'b00;
          r_done      <= 2'b00;
          r_err       <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.gnt               = r_gnt;
  assign io_bus.done              = r_done;
  assign io_bus.err               = r_err;
  assign io_bus.rdata             = r_rdata;
  assign io_bus.MemBus_Address    = r_addr;
  assign io_bus.MemBus_Write_Data = r_wdata;
  assign io_bus.MemRead           = r_mem_read;
  assign io_bus.MemWrite          = r_mem_write;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations plus randomized traffic.
// Latency: a transaction-level model predicts every output each cycle.
// Backpressure: Device_Ready is randomized per traffic block, including long stalls that force timeouts.
module tb_mem_bus_arbiter;
  localparam int          TIMEOUT = 15;
  localparam logic [31:0] RD_ERR  = 32'h0000_0000;

  logic clk;
  logic reset;
  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .RD_ERR_VALUE(RD_ERR)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [1:0]  e_gnt, e_done;
  logic        e_err, e_rd, e_wr;
  logic [31:0] e_rdata, e_addr, e_wdata;
  bit          txn_open, txn_closing, t_we;
  int          access_cycles, last_owner, owner;

  initial begin
    e_gnt = 0; e_done = 0; e_err = 0; e_rd = 0; e_wr = 0;
    e_rdata = 0; e_addr = 0; e_wdata = 0;
    txn_open = 0; txn_closing = 0; t_we = 0;
    access_cycles = 0; last_owner = 1; owner = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        e_gnt = 0; e_done = 0; e_err = 0; e_rd = 0; e_wr = 0;
        e_rdata = 0; e_addr = 0; e_wdata = 0;
        txn_open = 0; txn_closing = 0; last_owner = 1;
      end else if (txn_closing) begin
        // the completion cycle has been shown; bus goes back to free
        txn_closing = 0;
        e_done = 0; e_err = 0; e_gnt = 0;
      end else if (txn_open) begin
        access_cycles++;  // bus cycles used by this transaction so far
        if (bus.Device_Ready || access_cycles == TIMEOUT + 1) begin
          txn_open = 0;
          txn_closing = 1;
          e_done = e_gnt;
          e_err = !bus.Device_Ready;
          if (!t_we) e_rdata = bus.Device_Ready ? bus.Device_Read_Data : RD_ERR;
          e_rd = 0; e_wr = 0;
        end
      end else if (bus.m0_req || bus.m1_req) begin
        if (bus.m0_req && bus.m1_req) owner = 1 - last_owner;
        else owner = bus.m1_req ? 1 : 0;
        last_owner = owner;
        txn_open = 1;
        access_cycles = 0;
        t_we    = (owner == 1) ? bus.m1_we : bus.m0_we;
        e_addr  = (owner == 1) ? bus.m1_addr : bus.m0_addr;
        e_wdata = (owner == 1) ? bus.m1_wdata : bus.m0_wdata;
        e_gnt   = (owner == 1) ? 2'b10 : 2'b01;
        e_rd    = !t_we;
        e_wr    = t_we;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_gnt",   32'(bus.gnt),  32'(e_gnt));
        chk("m_done",  32'(bus.done), 32'(e_done));
        chk("m_err",   32'(bus.err),  32'(e_err));
        chk("m_rdata", bus.rdata, e_rdata);
        chk("m_addr",  bus.MemBus_Address, e_addr);
        chk("m_wdata", bus.MemBus_Write_Data, e_wdata);
        chk("m_rd",    32'(bus.MemRead),  32'(e_rd));
        chk("m_wr",    32'(bus.MemWrite), 32'(e_wr));
        chk("m_excl",  32'(bus.MemRead & bus.MemWrite), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
    chk({tag, "_addr"},  bus.MemBus_Address, 32'd0);
    chk({tag, "_wdata"}, bus.MemBus_Write_Data, 32'd0);
    chk({tag, "_rd"},    32'(bus.MemRead), 32'd0);
    chk({tag, "_wr"},    32'(bus.MemWrite), 32'd0);
  endtask

  int pct_tbl[4] = '{50, 10, 90, 0};

  initial begin
    reset = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.Device_Ready = 0; bus.Device_Read_Data = 0;
    step();
    cmp_en = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    all_zero("rst");

    // m0 read, device ready at once
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h4000_0010;
    bus.Device_Ready = 1; bus.Device_Read_Data = 32'h1234_5678;
    step();
    bus.m0_req = 0;
    @(negedge clk);
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_rd", 32'(bus.MemRead), 32'h1);
    chk("t1_addr", bus.MemBus_Address, 32'h4000_0010);
    step();
    @(negedge clk);
    chk("t1_done", 32'(bus.done), 32'h1);
    chk("t1_rdata", bus.rdata, 32'h1234_5678);
    chk("t1_err", 32'(bus.err), 32'h0);
    chk("t1_rd_off", 32'(bus.MemRead), 32'h0);
    step();
    @(negedge clk);
    chk("t1_idle_gnt", 32'(bus.gnt), 32'h0);

    // both requesting from reset, held: alternate m0, m1, m0, m1
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.m0_req = 1; bus.m1_req = 1; bus.m0_we = 0; bus.m1_we = 0;
    bus.m1_addr = 32'h0000_0080;
    for (int g = 0; g < 4; g++) begin
      step();
      @(negedge clk);
      chk("t2_gnt", 32'(bus.gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
      step();
      @(negedge clk);
      chk("t2_done", 32'(bus.done), (g % 2 == 0) ? 32'h1 : 32'h2);
      step();
      if (g == 3) begin
        bus.m0_req = 0; bus.m1_req = 0;
      end
      @(negedge clk);
      chk("t2_idle", 32'(bus.gnt), 32'h0);
    end

    // m1 write with three stall cycles; changed inputs after grant are ignored
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h0000_0100; bus.m1_wdata = 32'hCAFE_F00D;
    bus.Device_Ready = 0; bus.Device_Read_Data = 32'hDEAD_BEEF;
    step();
    bus.m1_req = 0; bus.m1_wdata = 32'h0; bus.m1_we = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.Device_Ready = 1;
      @(negedge clk);
      chk("t3_wr", 32'(bus.MemWrite), 32'h1);
      chk("t3_wdata", bus.MemBus_Write_Data, 32'hCAFE_F00D);
      step();
    end
    @(negedge clk);
    chk("t3_done", 32'(bus.done), 32'h2);
    chk("t3_err", 32'(bus.err), 32'h0);
    chk("t3_rdata", bus.rdata, 32'h1234_5678);
    chk("t3_wr_off", 32'(bus.MemWrite), 32'h0);
    step();
    bus.Device_Ready = 0;

    // m0 read that never gets Device_Ready: timeout after 16 cycles
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_0200;
    step();
    bus.m0_req = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t4_rd", 32'(bus.MemRead), 32'h1);
      step();
    end
    @(negedge clk);
    chk("t4_done", 32'(bus.done), 32'h1);
    chk("t4_err", 32'(bus.err), 32'h1);
    chk("t4_rdata", bus.rdata, 32'h0);
    chk("t4_rd_off", 32'(bus.MemRead), 32'h0);
    step();

    // Device_Ready arrives on the last allowed cycle: success
    bus.m0_req = 1; bus.Device_Read_Data = 32'hA5A5_5A5A;
    step();
    bus.m0_req = 0;
    for (int i = 0; i < 15; i++) step();
    bus.Device_Ready = 1;
    @(negedge clk);
    chk("t5_rd", 32'(bus.MemRead), 32'h1);
    step();
    @(negedge clk);
    chk("t5_done", 32'(bus.done), 32'h1);
    chk("t5_err", 32'(bus.err), 32'h0);
    chk("t5_rdata", bus.rdata, 32'hA5A5_5A5A);
    step();
    bus.Device_Ready = 0;

    // reset while m1 owns the bus, then a tie after release goes to m0
    bus.m1_req = 1; bus.m1_we = 0;
    step();
    bus.m1_req = 0;
    @(negedge clk);
    chk("t6_gnt", 32'(bus.gnt), 32'h2);
    step();
    reset = 1; bus.m0_req = 1; bus.m1_req = 1;
    step();
    reset = 0;
    @(negedge clk);
    all_zero("t6_rst");
    step();
    bus.m0_req = 0; bus.m1_req = 0; bus.Device_Ready = 1;
    @(negedge clk);
    chk("t6_tie_gnt", 32'(bus.gnt), 32'h1);
    step();
    @(negedge clk);
    chk("t6_done", 32'(bus.done), 32'h1);
    step();

    // randomized traffic in blocks of different device responsiveness
    for (int blk = 0; blk < 4; blk++) begin
      for (int n = 0; n < 500; n++) begin
        reset            = ($urandom_range(0, 199) == 0);
        bus.m0_req       = ($urandom_range(0, 99) < 40);
        bus.m1_req       = ($urandom_range(0, 99) < 40);
        bus.m0_we        = $urandom_range(0, 1);
        bus.m1_we        = $urandom_range(0, 1);
        bus.m0_addr      = $urandom;
        bus.m1_addr      = $urandom;
        bus.m0_wdata     = $urandom;
        bus.m1_wdata     = $urandom;
        bus.Device_Ready = ($urandom_range(0, 99) < pct_tbl[blk]);
        bus.Device_Read_Data = $urandom;
        step();
      end
    end
    reset = 0; bus.m0_req = 0; bus.m1_req = 0; bus.Device_Ready = 1;
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
